// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one bus transaction per instruction, load align/extend.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
  parameter int         TIMEOUT_W = 8,
  parameter logic [3:0] WE_NONE   = 4'b1111
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_read_in,
  input  logic [3:0]  mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  input  logic [2:0]  funct3_in,
  input  logic        flush_in,
  output logic        dm_req,
  output logic [3:0]  dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ready,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid_out,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign_err_out,
`endif
  output logic        bus_err_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           we_q;
  logic [2:0]           f3_q;
  logic                 rd_q;
  logic                 is_load;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_hit;
  logic                 access;
  logic                 misalign;
  logic [31:0]          aligned;

  assign access  = !flush_in &
                   (mem_read_in | (mem_write_in != WE_NONE));
  assign is_load = rd_q & (we_q == WE_NONE);
  assign wd_hit  = (wd_cnt == '1);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = access &
    (((funct3_in[1:0] == 2'b01) & addr_in[0]) |
     ((funct3_in[1:0] == 2'b10) & (addr_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (misalign)    state_nxt = DONE;
        else if (access) state_nxt = REQ;
      end
      REQ: begin
        if (dm_ready)    state_nxt = is_load ? WAIT_R : DONE;
        else if (wd_hit) state_nxt = DONE;
      end
      WAIT_R: begin
        if (dm_rvalid || wd_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dm_req    = 1'b0;
    dm_we     = WE_NONE;
    stall_out = 1'b0;
    unique case (state)
      IDLE:   stall_out = access;
      REQ: begin
        dm_req    = 1'b1;
        dm_we     = we_q;
        stall_out = 1'b1;
      end
      WAIT_R: stall_out = 1'b1;
      DONE:   stall_out = 1'b0;
      default: stall_out = 1'b0;
    endcase
  end

  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_wdata = wdata_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= WE_NONE;
      f3_q    <= '0;
      rd_q    <= 1'b0;
    end else if (state == IDLE && access) begin
      addr_q  <= addr_in;
      wdata_q <= store_data_in;
      we_q    <= mem_write_in;
      f3_q    <= funct3_in;
      rd_q    <= mem_read_in;
    end
  end

  // Counter restarts on each phase of the access so REQ and WAIT_R each get a full budget.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else begin
      unique case (state)
        IDLE:    wd_cnt <= '0;
        REQ:     wd_cnt <= dm_ready ? '0 : wd_cnt + 1'b1;
        WAIT_R:  wd_cnt <= wd_cnt + 1'b1;
        default: wd_cnt <= wd_cnt;
      endcase
    end
  end

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = dm_rdata[8*addr_q[1:0] +: 8];
    h = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (f3_q)
      3'b000:  aligned = {{24{b[7]}}, b};
      3'b001:  aligned = {{16{h[15]}}, h};
      3'b100:  aligned = {24'd0, b};
      3'b101:  aligned = {16'd0, h};
      default: aligned = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      load_valid_out <= 1'b0;
      bus_err_out    <= 1'b0;
      if (state == WAIT_R && dm_rvalid) begin
        load_data_out  <= aligned;
        load_valid_out <= 1'b1;
      end else if (wd_hit &&
                   ((state == REQ && !dm_ready) || state == WAIT_R)) begin
        bus_err_out <= 1'b1;
        if (is_load) load_data_out <= '0;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) misalign_err_out <= 1'b0;
    else         misalign_err_out <= (state == IDLE) && misalign;
  end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed testbench for mem_stage_lsu.
// Hand-computed vectors for loads, stores, flush, watchdog and reset.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_read_in;
  logic [3:0]  mem_write_in;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [2:0]  funct3_in;
  logic        flush_in;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ready;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        bus_err_out;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk            (clk),
    .resetn         (resetn),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .funct3_in      (funct3_in),
    .flush_in       (flush_in),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_ready       (dm_ready),
    .dm_rvalid      (dm_rvalid),
    .dm_rdata       (dm_rdata),
    .stall_out      (stall_out),
    .load_data_out  (load_data_out),
    .load_valid_out (load_valid_out),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_err_out (misalign_err_out),
`endif
    .bus_err_out    (bus_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a,
                         input logic [2:0] f, input logic [31:0] d,
                         input logic [31:0] exp);
    mem_read_in = 1'b1;
    addr_in     = a;
    funct3_in   = f;
    #1 chk({tag, "_idle_stall"}, 32'(stall_out), 32'd1);
    tick();
    mem_read_in = 1'b0;
    dm_ready    = 1'b1;
    #1 chk({tag, "_req"}, 32'(dm_req), 32'd1);
    chk({tag, "_addr"}, dm_addr, {a[31:2], 2'b00});
    tick();
    dm_ready  = 1'b0;
    dm_rvalid = 1'b1;
    dm_rdata  = d;
    tick();
    dm_rvalid = 1'b0;
    #1 chk({tag, "_valid"}, 32'(load_valid_out), 32'd1);
    chk({tag, "_data"}, load_data_out, exp);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    tick();
  endtask

  initial begin
    int n;
    resetn        = 1'b0;
    mem_read_in   = 1'b0;
    mem_write_in  = 4'b1111;
    addr_in       = '0;
    store_data_in = '0;
    funct3_in     = 3'b010;
    flush_in      = 1'b0;
    dm_ready      = 1'b0;
    dm_rvalid     = 1'b0;
    dm_rdata      = '0;
    tick();
    tick();
    chk("rst_req", 32'(dm_req), 32'd0);
    chk("rst_we", 32'(dm_we), 32'hF);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_ldata", load_data_out, 32'd0);
    chk("rst_lvalid", 32'(load_valid_out), 32'd0);
    chk("rst_berr", 32'(bus_err_out), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    resetn = 1'b1;
    tick();

    // LW 0x100: ready on cycle 2, rvalid on cycle 4
    mem_read_in = 1'b1;
    addr_in     = 32'h100;
    funct3_in   = 3'b010;
    #1 chk("lw_c0_stall", 32'(stall_out), 32'd1);
    tick();
    mem_read_in = 1'b0;
    #1 chk("lw_c1_req", 32'(dm_req), 32'd1);
    chk("lw_c1_addr", dm_addr, 32'h100);
    chk("lw_c1_we", 32'(dm_we), 32'hF);
    chk("lw_c1_stall", 32'(stall_out), 32'd1);
    tick();
    dm_ready = 1'b1;
    #1 chk("lw_c2_req", 32'(dm_req), 32'd1);
    tick();
    dm_ready = 1'b0;
    #1 chk("lw_c3_req", 32'(dm_req), 32'd0);
    chk("lw_c3_stall", 32'(stall_out), 32'd1);
    tick();
    dm_rvalid = 1'b1;
    dm_rdata  = 32'hDEADBEEF;
    #1 chk("lw_c4_stall", 32'(stall_out), 32'd1);
    tick();
    dm_rvalid = 1'b0;
    #1 chk("lw_c5_stall", 32'(stall_out), 32'd0);
    chk("lw_c5_valid", 32'(load_valid_out), 32'd1);
    chk("lw_c5_data", load_data_out, 32'hDEADBEEF);
    tick();
    chk("lw_c6_valid", 32'(load_valid_out), 32'd0);
    chk("lw_c6_hold", load_data_out, 32'hDEADBEEF);

    do_load("lb103", 32'h103, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu103", 32'h103, 3'b100, 32'h80FF_0000, 32'h0000_0080);
    do_load("lb102", 32'h102, 3'b000, 32'h80FF_0000, 32'hFFFF_FFFF);
    do_load("lhu102", 32'h102, 3'b101, 32'h8001_0000, 32'h0000_8001);
    do_load("lh100", 32'h100, 3'b001, 32'h1234_8765, 32'hFFFF_8765);

    // SB 0x203 with 3 cycles of backpressure
    mem_write_in  = 4'b0111;
    store_data_in = 32'hAB00_0000;
    addr_in       = 32'h203;
    funct3_in     = 3'b000;
    #1 chk("sb_idle_stall", 32'(stall_out), 32'd1);
    tick();
    mem_write_in  = 4'b1111;
    store_data_in = 32'h0;
    addr_in       = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("sb_wait_req", 32'(dm_req), 32'd1);
      chk("sb_wait_addr", dm_addr, 32'h200);
      chk("sb_wait_we", 32'(dm_we), 32'h7);
      chk("sb_wait_wdata", dm_wdata, 32'hAB00_0000);
      tick();
    end
    dm_ready = 1'b1;
    #1 chk("sb_rdy_we", 32'(dm_we), 32'h7);
    tick();
    dm_ready = 1'b0;
    #1 chk("sb_done_stall", 32'(stall_out), 32'd0);
    chk("sb_done_valid", 32'(load_valid_out), 32'd0);
    chk("sb_done_req", 32'(dm_req), 32'd0);
    chk("sb_done_ldata", load_data_out, 32'hFFFF_8765);
    tick();

    // Flushed load makes no access
    mem_read_in = 1'b1;
    flush_in    = 1'b1;
    addr_in     = 32'h400;
    #1 chk("fl_stall", 32'(stall_out), 32'd0);
    chk("fl_req", 32'(dm_req), 32'd0);
    tick();
    chk("fl_req2", 32'(dm_req), 32'd0);
    mem_read_in = 1'b0;
    flush_in    = 1'b0;
    tick();

    // Watchdog: dm_ready never asserted
    mem_read_in = 1'b1;
    addr_in     = 32'h300;
    funct3_in   = 3'b010;
    #1;
    tick();
    mem_read_in = 1'b0;
    n = 0;
    while (dm_req && n < 400) begin
      n++;
      tick();
    end
    chk("wd_req_cycles_ok", 32'(n >= 255 && n <= 256), 32'd1);
    chk("wd_berr", 32'(bus_err_out), 32'd1);
    chk("wd_ldata", load_data_out, 32'd0);
    chk("wd_stall", 32'(stall_out), 32'd0);
    chk("wd_valid", 32'(load_valid_out), 32'd0);
    tick();
    chk("wd_berr_pulse", 32'(bus_err_out), 32'd0);

    // Async reset in WAIT_R, then LH 0x102
    do_load("pre", 32'h104, 3'b010, 32'h5555_AAAA, 32'h5555_AAAA);
    mem_read_in = 1'b1;
    addr_in     = 32'h108;
    #1;
    tick();
    mem_read_in = 1'b0;
    dm_ready    = 1'b1;
    #1;
    tick();
    dm_ready = 1'b0;
    #1 chk("wr_stall", 32'(stall_out), 32'd1);
    resetn = 1'b0;
    #1 chk("ar_req", 32'(dm_req), 32'd0);
    chk("ar_stall_idle", 32'(stall_out), 32'd0);
    chk("ar_ldata", load_data_out, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("ar_idle_req", 32'(dm_req), 32'd0);
    do_load("lh102", 32'h102, 3'b001, 32'h8001_0000, 32'hFFFF_8001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation bound reached");
    $fatal(1, "bound");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Consumer end of the EX/MEM pipeline register. It takes the registered memory-stage control and data, runs one data-memory transaction per instruction on a valid/ready request bus, and aligns and sign-extends load data for write-back.
- Drives `stall_out`, which feeds the NOP/hold input of the IF/ID, ID/EX and EX/MEM registers, so the pipeline freezes while an access is outstanding.

Parameters:
- TIMEOUT_W, 8: width of the response watchdog counter. Timeout fires after 2^TIMEOUT_W - 1 cycles without progress.
- WE_NONE, 4'b1111: encoding of "no byte write" on the active-low write enables.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- mem_read_in  in  1  load request from EX/MEM
- mem_write_in  in  4  active-low byte write enables from EX/MEM; 4'b1111 means no store
- addr_in  in  32  effective address (ALU result) from EX/MEM
- store_data_in  in  32  store data, already lane-shifted upstream
- funct3_in  in  3  load/store size and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- flush_in  in  1  EX/MEM flush; the instruction is squashed and no access is made
- dm_req  out  1  bus request valid
- dm_we  out  4  active-low byte write enables to memory
- dm_addr  out  32  word-aligned bus address
- dm_wdata  out  32  bus write data
- dm_ready  in  1  bus accepts the request when dm_req & dm_ready
- dm_rvalid  in  1  read data valid
- dm_rdata  in  32  read data word
- stall_out  out  1  pipeline hold (NOP) request
- load_data_out  out  32  aligned, extended load result
- load_valid_out  out  1  one-cycle pulse when load_data_out is updated
- bus_err_out  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Request condition: `access = !flush_in & (mem_read_in | (mem_write_in != 4'b1111))`.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - `stall_out = access`, combinational, same cycle.
  - If access: capture addr_in, store_data_in, mem_write_in, funct3_in and mem_read_in into internal registers, then go to REQ.
  - If mem_read_in and a write enable are both asserted, the access is treated as a write.
- REQ:
  - dm_req = 1. dm_addr = {addr[31:2], 2'b00}, dm_we = captured enables (4'b1111 for loads), dm_wdata = captured data.
  - All bus outputs stay stable until dm_ready.
  - On dm_ready: a store goes to DONE, a load goes to WAIT_R.
- WAIT_R:
  - dm_req = 0, dm_we = 4'b1111.
  - On dm_rvalid: register the aligned data and go to DONE.
  - dm_rvalid arriving in the same cycle as dm_ready in REQ is not supported; the bus guarantees at least one cycle between them.
- DONE:
  - stall_out = 0, so the pipeline advances at the end of this cycle.
  - load_valid_out = 1 for a completed load.
  - Inputs are ignored in this cycle. Go to IDLE.
- stall_out = 1 in REQ and WAIT_R.
- Load alignment uses offset o = addr[1:0]:
  - LB/LBU: byte o, sign- or zero-extended.
  - LH/LHU: halfword at addr[1], sign- or zero-extended.
  - LW: the full word.
- load_data_out holds its value until the next load completes.
- Watchdog:
  - The counter clears when entering REQ and when moving REQ -> WAIT_R, and increments every cycle spent in REQ or WAIT_R.
  - At all-ones the block drops dm_req, goes to DONE, pulses bus_err_out, and sets load_data_out = 0 if the access was a load.
- flush_in is sampled only in IDLE; an accepted access always completes.
- Reset values, with asynchronous reset from any state: state IDLE, dm_req 0, dm_we 4'b1111, dm_addr 0, dm_wdata 0, load_data_out 0, load_valid_out 0, bus_err_out 0, watchdog 0. stall_out follows the IDLE equation.

Optional Feature:
- Macro: `LSU_MISALIGN_TRAP_EN`.
- When defined:
  - In IDLE, an access with LH/LHU/SH and addr[0] = 1, or LW/SW and addr[1:0] != 0, is not issued.
  - The FSM goes IDLE -> DONE with stall_out = 1 for that one IDLE cycle.
  - New output `misalign_err_out` (1 bit, reset 0) pulses in DONE; load_data_out is unchanged and load_valid_out = 0.
- When undefined: the port is absent, low address bits are ignored for the bus address, and alignment follows the rules above.

Test Plan:
- LW, addr 0x100, dm_ready on cycle 2, dm_rvalid with 0xDEADBEEF on cycle 4:
  - dm_addr = 0x100 and dm_we = 4'b1111 in REQ.
  - load_data_out = 0xDEADBEEF with a load_valid_out pulse.
  - stall_out is high from the IDLE cycle through WAIT_R and low in DONE.
- LB addr 0x103 and LBU addr 0x103, dm_rdata 0x80FF_0000:
  - LB gives 0xFFFFFF80.
  - LBU gives 0x00000080.
- SB, mem_write_in = 4'b0111, store data 0xAB000000, addr 0x203:
  - dm_addr = 0x200, dm_we = 4'b0111, dm_wdata = 0xAB000000.
  - With dm_ready held low for 3 cycles, all three stay stable until ready; then DONE with no load_valid_out.
- flush_in = 1 with mem_read_in = 1:
  - No dm_req, stall_out = 0.
- Load with dm_ready tied to 0:
  - After 255 cycles, bus_err_out pulses, load_data_out = 0, stall_out releases.
- Assert resetn = 0 during WAIT_R:
  - dm_req = 0 and state IDLE immediately.
  - After release, an LH at 0x102 with dm_rdata 0x8001_0000 gives 0xFFFF8001.
